mem_arbiter: RTL and testbench

Single-port memory arbiter that lets the instruction-fetch path and the load/store path share one synchronous single-port `ram` instance. Sits between the register-file/PC logic (fetch requester), the load/store datapath (data requester) and the RAM. It issues at most one RAM access per cycle and routes read data back with a one-cycle response tag. Data accesses have priority; an optional starvation guard bounds fetch latency.

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store,
// data first. Optional fetch starvation guard enabled by `MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_ad,
    output logic [31:0] mem_d,
    output logic        mem_we,
    input  logic [31:0] mem_q
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StRespIf,
        StRespD
    } resp_e;

    resp_e       resp_q, resp_d;
    logic [31:0] last_ad_q;
    logic        force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_if = if_req && (starve_q == Limit);

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q != Limit) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^Limit;
    assign force_if     = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the RAM while nreset is low.
    assign if_gnt = nreset & if_req & (~d_req | force_if);
    assign d_gnt  = nreset & d_req & ~(if_req & force_if);

    always_comb begin
        if (if_gnt) begin
            mem_ad = if_addr;
        end else if (d_gnt) begin
            mem_ad = d_addr;
        end else begin
            mem_ad = last_ad_q;
        end
    end

    assign mem_we = d_gnt & d_we;
    assign mem_d  = d_wdata;

    always_comb begin
        resp_d = StIdle;
        if (if_gnt) begin
            resp_d = StRespIf;
        end else if (d_gnt && !d_we) begin
            resp_d = StRespD;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            resp_q    <= StIdle;
            last_ad_q <= 32'd0;
        end else begin
            resp_q    <= resp_d;
            last_ad_q <= mem_ad;
        end
    end

    assign if_rvalid = (resp_q == StRespIf);
    assign d_rvalid  = (resp_q == StRespD);
    assign if_rdata  = mem_q;
    assign d_rdata   = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a behavioural RAM and a
// cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_ad, mem_d;
    logic [31:0] mem_q;

    int checks = 0;
    int errors = 0;

    // Behavioural RAM seen by the DUT and the model's own copy of its contents.
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];

    // Reference model state.
    int          wait_cnt;
    logic [31:0] last_ad;
    bit          pend_if, pend_d;
    logic [31:0] pend_data;
    bit          exp_ig, exp_dg;
    int          if_grants;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_ad   (mem_ad),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    always_ff @(posedge clk) begin
        if (mem_we) ram[mem_ad[9:2]] <= mem_d;
        mem_q <= ram[mem_ad[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        logic [31:0] ead;
        bit          ewe, vif, vd;
        @(negedge clk);
        exp_ig = nreset && if_req && (!d_req || (GUARD && wait_cnt >= LIMIT));
        exp_dg = nreset && d_req && !exp_ig;
        ead    = exp_ig ? if_addr : exp_dg ? d_addr : (nreset ? last_ad : 32'd0);
        ewe    = exp_dg && d_we;
        vif    = pend_if && nreset;
        vd     = pend_d && nreset;
        check("if_gnt", 32'(if_gnt), 32'(exp_ig));
        check("d_gnt", 32'(d_gnt), 32'(exp_dg));
        check("mem_ad", mem_ad, ead);
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("if_rvalid", 32'(if_rvalid), 32'(vif));
        check("d_rvalid", 32'(d_rvalid), 32'(vd));
        if (vif) check("if_rdata", if_rdata, pend_data);
        if (vd) check("d_rdata", d_rdata, pend_data);
        if (if_gnt) if_grants++;
        @(posedge clk);
        if (!nreset) begin
            wait_cnt = 0;
            last_ad  = 32'd0;
            pend_if  = 1'b0;
            pend_d   = 1'b0;
        end else begin
            pend_if   = exp_ig;
            pend_d    = exp_dg && !d_we;
            pend_data = ref_mem[ead[9:2]];
            if (ewe) ref_mem[ead[9:2]] = d_wdata;
            last_ad = ead;
            if (if_req && !exp_ig) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
            else wait_cnt = 0;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom), 2'b00};
    endfunction

    initial begin
        logic [31:0] v;
        nreset = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        wait_cnt = 0; last_ad = '0; pend_if = 0; pend_d = 0; pend_data = '0;
        if_grants = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[0] = 32'hAAAA_0001; ref_mem[0] = 32'hAAAA_0001;
        ram[1] = 32'hBBBB_0002; ref_mem[1] = 32'hBBBB_0002;
        ram[2] = 32'hCCCC_0003; ref_mem[2] = 32'hCCCC_0003;

        // Reset state.
        #1;
        cycle();
        cycle();
        nreset = 1'b1;

        // Solo fetch stream 0, 4, 8.
        if_req = 1'b1;
        if_addr = 32'h0; cycle();
        if_addr = 32'h4; cycle();
        if_addr = 32'h8; cycle();
        if_req = 1'b0; cycle();
        cycle();

        // Reset with a fetch response pending.
        if_req = 1'b1; if_addr = 32'h10; cycle();
        if_req = 1'b0; nreset = 1'b0;
        cycle();
        nreset = 1'b1;
        cycle();
        cycle();

        // Conflict: load wins, fetch follows.
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        cycle();
        d_req = 1'b0; cycle();
        if_req = 1'b0; cycle();

        // Store, then read it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
        cycle();
        d_req = 1'b0; d_we = 1'b0; cycle();
        d_req = 1'b1; d_addr = 32'h8; cycle();
        d_req = 1'b0; cycle();
        check("store_readback", ref_mem[2], 32'hDEAD_BEEF);

        // Starvation: both requesters held for 20 cycles.
        if_grants = 0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (exp_ig) if_addr = rand_addr();
            if (exp_dg) d_addr = rand_addr();
        end
        check("starve_if_grants", 32'(if_grants), GUARD ? 32'(20 / (LIMIT + 1)) : 32'd0);
        if_req = 1'b0; d_req = 1'b0; cycle();

        // Randomized traffic obeying the hold-until-grant protocol.
        for (int c = 0; c < 400; c++) begin
            if (!if_req || exp_ig) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!d_req || exp_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            if (c == 200) nreset = 1'b0;
            if (c == 203) nreset = 1'b1;
            exp_ig = 1'b0; exp_dg = 1'b0;
            cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
